// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline stage directly downstream of execute. Issues data-memory loads and
// stores over a valid/ready request bus with a separate response-valid bus,
// aligns and extends load data, and forwards ALU/branch results, flags and
// exceptions to writeback. Execute is stalled while an access is outstanding.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in*                 uop from execute (valid, rd, result/address, store data,
//                       ld/st kind, size, sign-extend, flags, exception)
//   inStall             execute must hold its uop (registered: state != IDLE)
//   dmemReq*            request: valid/ready handshake, we, word address,
//                       lane-replicated write data, byte enables
//   dmemResp*           load response: valid strobe and full data word
//   out*                registered uop to writeback
//   byp*                mem-stage bypass seen by execute (derived from out*)
//
// The byte-lane logic (4-bit byte enables, lane replication) assumes XLEN = 32.
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int              XLEN        = 32,
  parameter int              REG_W       = 4,
  parameter int              EX_W        = 4,
  parameter logic [EX_W-1:0] EX_MISALIGN = 4'h4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             inValid,
  output logic             inStall,
  input  logic [REG_W-1:0] inRd,
  input  logic [XLEN-1:0]  inRdVal,
  input  logic [XLEN-1:0]  inRs2Val,
  input  logic             inIsLd,
  input  logic             inIsSt,
  input  logic [1:0]       inSize,
  input  logic             inSignExt,
  input  logic             inFlagsValid,
  input  logic [3:0]       inFlags,
  input  logic             inExValid,
  input  logic [EX_W-1:0]  inEx,

  output logic             dmemReqValid,
  input  logic             dmemReqReady,
  output logic             dmemReqWe,
  output logic [XLEN-3:0]  dmemReqAddr,
  output logic [XLEN-1:0]  dmemReqWdata,
  output logic [3:0]       dmemReqBe,
  input  logic             dmemRespValid,
  input  logic [XLEN-1:0]  dmemRespRdata,

  output logic             outValid,
  output logic [REG_W-1:0] outRd,
  output logic             outRdWrite,
  output logic [XLEN-1:0]  outRdVal,
  output logic             outFlagsValid,
  output logic [3:0]       outFlags,
  output logic             outExValid,
  output logic [EX_W-1:0]  outEx,

  output logic             bypRValid,
  output logic [REG_W-1:0] bypR,
  output logic [XLEN-1:0]  bypRVal,
  output logic             bypFlagsValid,
  output logic [3:0]       bypFlags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } stateT;

  stateT state;

  // Holding register: the memory uop being serviced while execute is stalled.
  logic [REG_W-1:0] hRd;
  logic [XLEN-1:0]  hAddr;
  logic [XLEN-1:0]  hData;
  logic             hIsLd;
  logic [1:0]       hSize;
  logic             hSignExt;
  logic             hFlagsValid;
  logic [3:0]       hFlags;

  logic             inIsMem;
  logic             inIllegal;
  logic [XLEN-1:0]  laneShift;
  logic [XLEN-1:0]  loadVal;

  assign inIsMem = inIsLd | inIsSt;

  // Size 11 is illegal; halves need addr[0]==0, words need addr[1:0]==0.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    inIllegal = 1'b0;
    unique case (inSize)
      2'b00:   inIllegal = 1'b0;
      2'b01:   inIllegal = inRdVal[0];
      2'b10:   inIllegal = |inRdVal[1:0];
      default: inIllegal = 1'b1;
    endcase
  end

  // Request fields come straight from the holding register, so they stay
  // stable for as long as the memory keeps ready low.
  assign dmemReqValid = (state == REQ);
  assign dmemReqWe    = ~hIsLd;
  assign dmemReqAddr  = hAddr[XLEN-1:2];

  always_comb begin
    dmemReqBe    = 4'b1111;
    dmemReqWdata = hData;
    unique case (hSize)
      2'b00: begin
        dmemReqBe    = 4'b0001 << hAddr[1:0];
        dmemReqWdata = {4{hData[7:0]}};
      end
      2'b01: begin
        dmemReqBe    = hAddr[1] ? 4'b1100 : 4'b0011;
        dmemReqWdata = {2{hData[15:0]}};
      end
      default: begin
        dmemReqBe    = 4'b1111;
        dmemReqWdata = hData;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then mask and extend to size.
  assign laneShift = dmemRespRdata >> {hAddr[1:0], 3'b000};

  always_comb begin
    loadVal = laneShift;
    unique case (hSize)
      2'b00:   loadVal = {{(XLEN-8){hSignExt & laneShift[7]}}, laneShift[7:0]};
      2'b01:   loadVal = {{(XLEN-16){hSignExt & laneShift[15]}}, laneShift[15:0]};
      default: loadVal = laneShift;
    endcase
  end

  // Stall is pure registered state, never a path from inValid.
  assign inStall = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the holding register is cleared on reset even though it is
      // always rewritten before use, so an aborted access leaves no residue.
      state         <= IDLE;
      hRd           <= '0;
      hAddr         <= '0;
      hData         <= '0;
      hIsLd         <= 1'b0;
      hSize         <= 2'b00;
      hSignExt      <= 1'b0;
      hFlagsValid   <= 1'b0;
      hFlags        <= '0;
      outValid      <= 1'b0;
      outRd         <= '0;
      outRdWrite    <= 1'b0;
      outRdVal      <= '0;
      outFlagsValid <= 1'b0;
      outFlags      <= '0;
      outExValid    <= 1'b0;
      outEx         <= '0;
    end else begin
      outValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inValid) begin
            if (!inIsMem || inExValid || inIllegal) begin
              // Single-cycle pass-through: ALU ops, carried exceptions and
              // rejected memory ops never touch the bus.
              outValid      <= 1'b1;
              outRd         <= inRd;
              outRdVal      <= inRdVal;
              outFlagsValid <= inFlagsValid;
              outFlags      <= inFlags;
              if (inExValid) begin
                outExValid <= 1'b1;
                outEx      <= inEx;
                outRdWrite <= 1'b0;
              end else if (inIsMem) begin
                outExValid <= 1'b1;
                outEx      <= EX_MISALIGN;
                outRdWrite <= 1'b0;
              end else begin
                outExValid <= 1'b0;
                outEx      <= '0;
                outRdWrite <= (inRd != '0);
              end
            end else begin
              hRd         <= inRd;
              hAddr       <= inRdVal;
              hData       <= inRs2Val;
              hIsLd       <= inIsLd;
              hSize       <= inSize;
              hSignExt    <= inSignExt;
              hFlagsValid <= inFlagsValid;
              hFlags      <= inFlags;
              state       <= REQ;
            end
          end
        end

        REQ: begin
          if (dmemReqReady) begin
            if (hIsLd) begin
              state <= WAIT;
            end else begin
              // Stores retire on acceptance; the result field carries the
              // effective address but is never written back.
              state         <= IDLE;
              outValid      <= 1'b1;
              outRd         <= hRd;
              outRdWrite    <= 1'b0;
              outRdVal      <= hAddr;
              outFlagsValid <= hFlagsValid;
              outFlags      <= hFlags;
              outExValid    <= 1'b0;
              outEx         <= '0;
            end
          end
        end

        WAIT: begin
          if (dmemRespValid) begin
            state         <= IDLE;
            outValid      <= 1'b1;
            outRd         <= hRd;
            outRdWrite    <= (hRd != '0);
            outRdVal      <= loadVal;
            outFlagsValid <= hFlagsValid;
            outFlags      <= hFlags;
            outExValid    <= 1'b0;
            outEx         <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bypRValid     = outValid & outRdWrite;
  assign bypR          = outRd;
  assign bypRVal       = outRdVal;
  assign bypFlagsValid = outValid & outFlagsValid;
  assign bypFlags      = outFlags;

  // A response strobe outside WAIT must not produce a writeback.
  respIgnoredInIdle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && !inValid) |=> (state == IDLE && !outValid));
  respIgnoredInReq: assert property (@(posedge clk) disable iff (!rst_n)
    (state == REQ && !dmemReqReady) |=> (state == REQ && !outValid));

endmodule
